// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter. The read path and the write path are arbitrated
// independently. Each path has a round-robin grant FSM and a tag FIFO that
// records which port owns every outstanding transaction. The FIFO steers the
// in-order memory responses back to the right requester.

module mem_port_arbiter_path #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic m_addr_ack,
    input  logic m_ack,
    output logic m_req,
    output logic sel,
    output logic addr_ack0,
    output logic addr_ack1,
    output logic ack0,
    output logic ack1
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t           state;
    logic             rr_favor1;
    logic [DEPTH-1:0] tag_mem;
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count;
    logic             push;
    logic             pop;
    logic             head_tag;
    logic             can_grant;
    logic             pick1;

    // An address ack only counts while a grant is active. A data ack only
    // counts while the FIFO holds a tag.
    assign push     = (state != IDLE) && m_addr_ack;
    assign pop      = m_ack && (count != '0);
    assign head_tag = tag_mem[rd_ptr];

    // The full check uses the registered count. A pop in the same cycle
    // therefore frees its slot for the next cycle's decision, not this one.
    assign can_grant = (count < cnt_t'(DEPTH)) && (req0 || req1);
    assign pick1     = req1 && (!req0 || rr_favor1);

    assign m_req     = (state != IDLE);
    assign sel       = (state == GNT1);
    assign addr_ack0 = (state == GNT0) && m_addr_ack;
    assign addr_ack1 = (state == GNT1) && m_addr_ack;
    assign ack0      = pop && !head_tag;
    assign ack1      = pop && head_tag;

    // Tag storage: one bit per outstanding transaction, set for port 1.
    // NOTE: storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= (state == GNT1);
        end
    end

    // Grant FSM, round-robin pointer, and FIFO pointers/count.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_favor1 <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        state <= pick1 ? GNT1 : GNT0;
                    end
                end
                GNT0, GNT1: begin
                    // The grant stays locked until the memory takes the address.
                    if (m_addr_ack) begin
                        state     <= IDLE;
                        rr_favor1 <= (state == GNT0);
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_port_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_req,
    input  logic [ADDR_W-1:0] p0_rd_addr,
    output logic              p0_rd_addr_ack,
    output logic [DATA_W-1:0] p0_rd_data,
    output logic              p0_rd_ack,
    input  logic              p0_wr_req,
    input  logic [ADDR_W-1:0] p0_wr_addr,
    input  logic [DATA_W-1:0] p0_wr_data,
    output logic              p0_wr_addr_ack,
    output logic              p0_wr_ack,
    input  logic              p1_rd_req,
    input  logic [ADDR_W-1:0] p1_rd_addr,
    output logic              p1_rd_addr_ack,
    output logic [DATA_W-1:0] p1_rd_data,
    output logic              p1_rd_ack,
    input  logic              p1_wr_req,
    input  logic [ADDR_W-1:0] p1_wr_addr,
    input  logic [DATA_W-1:0] p1_wr_data,
    output logic              p1_wr_addr_ack,
    output logic              p1_wr_ack,
    output logic              m_rd_req,
    output logic [ADDR_W-1:0] m_rd_addr,
    input  logic              m_rd_addr_ack,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_ack,
    output logic              m_wr_req,
    output logic [ADDR_W-1:0] m_wr_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic              m_wr_addr_ack,
    input  logic              m_wr_ack
);
    logic rd_sel;
    logic wr_sel;

    mem_port_arbiter_path #(.DEPTH(DEPTH)) u_rd_path (
        .clk        (clk),
        .rst        (rst),
        .req0       (p0_rd_req),
        .req1       (p1_rd_req),
        .m_addr_ack (m_rd_addr_ack),
        .m_ack      (m_rd_ack),
        .m_req      (m_rd_req),
        .sel        (rd_sel),
        .addr_ack0  (p0_rd_addr_ack),
        .addr_ack1  (p1_rd_addr_ack),
        .ack0       (p0_rd_ack),
        .ack1       (p1_rd_ack)
    );

    mem_port_arbiter_path #(.DEPTH(DEPTH)) u_wr_path (
        .clk        (clk),
        .rst        (rst),
        .req0       (p0_wr_req),
        .req1       (p1_wr_req),
        .m_addr_ack (m_wr_addr_ack),
        .m_ack      (m_wr_ack),
        .m_req      (m_wr_req),
        .sel        (wr_sel),
        .addr_ack0  (p0_wr_addr_ack),
        .addr_ack1  (p1_wr_addr_ack),
        .ack0       (p0_wr_ack),
        .ack1       (p1_wr_ack)
    );

    // The granted port's request is muxed onto the memory side.
    assign m_rd_addr = rd_sel ? p1_rd_addr : p0_rd_addr;
    assign m_wr_addr = wr_sel ? p1_wr_addr : p0_wr_addr;
    assign m_wr_data = wr_sel ? p1_wr_data : p0_wr_data;

    // Read data is qualified by the per-port ack, so both ports can see the bus.
    assign p0_rd_data = m_rd_data;
    assign p1_rd_data = m_rd_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes the expected address
// acks and data acks into queues. A negedge monitor pops an entry and compares
// it whenever the DUT pulses an ack.

module tb_mem_port_arbiter;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_rd_req, p0_rd_addr_ack, p0_rd_ack;
    logic [ADDR_W-1:0] p0_rd_addr;
    logic [DATA_W-1:0] p0_rd_data;
    logic              p0_wr_req, p0_wr_addr_ack, p0_wr_ack;
    logic [ADDR_W-1:0] p0_wr_addr;
    logic [DATA_W-1:0] p0_wr_data;
    logic              p1_rd_req, p1_rd_addr_ack, p1_rd_ack;
    logic [ADDR_W-1:0] p1_rd_addr;
    logic [DATA_W-1:0] p1_rd_data;
    logic              p1_wr_req, p1_wr_addr_ack, p1_wr_ack;
    logic [ADDR_W-1:0] p1_wr_addr;
    logic [DATA_W-1:0] p1_wr_data;
    logic              m_rd_req, m_rd_addr_ack, m_rd_ack;
    logic [ADDR_W-1:0] m_rd_addr;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_wr_req, m_wr_addr_ack, m_wr_ack;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t rd_aq[$];
    exp_t rd_dq[$];
    exp_t wr_aq[$];
    exp_t wr_dq[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_rd_req(p0_rd_req), .p0_rd_addr(p0_rd_addr), .p0_rd_addr_ack(p0_rd_addr_ack),
        .p0_rd_data(p0_rd_data), .p0_rd_ack(p0_rd_ack),
        .p0_wr_req(p0_wr_req), .p0_wr_addr(p0_wr_addr), .p0_wr_data(p0_wr_data),
        .p0_wr_addr_ack(p0_wr_addr_ack), .p0_wr_ack(p0_wr_ack),
        .p1_rd_req(p1_rd_req), .p1_rd_addr(p1_rd_addr), .p1_rd_addr_ack(p1_rd_addr_ack),
        .p1_rd_data(p1_rd_data), .p1_rd_ack(p1_rd_ack),
        .p1_wr_req(p1_wr_req), .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data),
        .p1_wr_addr_ack(p1_wr_addr_ack), .p1_wr_ack(p1_wr_ack),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_addr_ack(m_rd_addr_ack),
        .m_rd_data(m_rd_data), .m_rd_ack(m_rd_ack),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_wr_addr_ack(m_wr_addr_ack), .m_wr_ack(m_wr_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int port);
        return (port == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic exp_t mk(input int port, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack pulse must match the head of its queue.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] seen;
        seen = {p1_rd_addr_ack, p0_rd_addr_ack};
        if (seen != 2'b00) begin
            if (rd_aq.size() == 0) check("rd_addr_ack_unexpected", 64'(seen), 64'd0);
            else begin
                e = rd_aq.pop_front();
                check("rd_addr_ack_port", 64'(seen), 64'(onehot(e.port)));
                check("m_rd_addr", 64'(m_rd_addr), 64'(e.addr));
            end
        end
        seen = {p1_rd_ack, p0_rd_ack};
        if (seen != 2'b00) begin
            if (rd_dq.size() == 0) check("rd_ack_unexpected", 64'(seen), 64'd0);
            else begin
                e = rd_dq.pop_front();
                check("rd_ack_port", 64'(seen), 64'(onehot(e.port)));
                check("rd_data", (e.port == 1) ? p1_rd_data : p0_rd_data, e.data);
            end
        end
        seen = {p1_wr_addr_ack, p0_wr_addr_ack};
        if (seen != 2'b00) begin
            if (wr_aq.size() == 0) check("wr_addr_ack_unexpected", 64'(seen), 64'd0);
            else begin
                e = wr_aq.pop_front();
                check("wr_addr_ack_port", 64'(seen), 64'(onehot(e.port)));
                check("m_wr_addr", 64'(m_wr_addr), 64'(e.addr));
                check("m_wr_data", m_wr_data, e.data);
            end
        end
        seen = {p1_wr_ack, p0_wr_ack};
        if (seen != 2'b00) begin
            if (wr_dq.size() == 0) check("wr_ack_unexpected", 64'(seen), 64'd0);
            else begin
                e = wr_dq.pop_front();
                check("wr_ack_port", 64'(seen), 64'(onehot(e.port)));
            end
        end
    end

    task automatic do_reset();
        rd_aq.delete();
        rd_dq.delete();
        wr_aq.delete();
        wr_dq.delete();
        rst = 1'b1;
        p0_rd_req = 1'b0; p1_rd_req = 1'b0; p0_wr_req = 1'b0; p1_wr_req = 1'b0;
        m_rd_addr_ack = 1'b0; m_rd_ack = 1'b0; m_wr_addr_ack = 1'b0; m_wr_ack = 1'b0;
        tick(2);
        check("reset_outputs",
              64'({m_rd_req, m_wr_req, p0_rd_addr_ack, p0_rd_ack, p0_wr_addr_ack, p0_wr_ack,
                   p1_rd_addr_ack, p1_rd_ack, p1_wr_addr_ack, p1_wr_ack}), 64'd0);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the path's memory request, then acks the address after
    // `delay` cycles. It can optionally pulse the data ack in the same cycle.
    task automatic addr_handshake(input bit wr, input int delay, input bit with_ack,
                                  input logic [DATA_W-1:0] ack_data, output int port);
        int n = 0;
        while (!(wr ? m_wr_req : m_rd_req) && n < 40) begin
            tick(1);
            n++;
        end
        check(wr ? "m_wr_req_wait" : "m_rd_req_wait", 64'(wr ? m_wr_req : m_rd_req), 64'd1);
        repeat (delay) @(posedge clk);
        #1;
        if (wr) m_wr_addr_ack = 1'b1;
        else    m_rd_addr_ack = 1'b1;
        if (with_ack) begin
            m_rd_data = ack_data;
            if (wr) m_wr_ack = 1'b1;
            else    m_rd_ack = 1'b1;
        end
        #1;
        port = (wr ? p1_wr_addr_ack : p1_rd_addr_ack) ? 1 : 0;
        tick(1);
        m_rd_addr_ack = 1'b0; m_wr_addr_ack = 1'b0; m_rd_ack = 1'b0; m_wr_ack = 1'b0;
    endtask

    task automatic mem_return(input bit wr, input logic [DATA_W-1:0] data);
        m_rd_data = data;
        if (wr) m_wr_ack = 1'b1;
        else    m_rd_ack = 1'b1;
        tick(1);
        m_rd_ack = 1'b0;
        m_wr_ack = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int port;
        rst = 1'b1;
        p0_rd_addr = '0; p1_rd_addr = '0; p0_wr_addr = '0; p1_wr_addr = '0;
        p0_wr_data = '0; p1_wr_data = '0; m_rd_data = '0;
        do_reset();

        // Stray address and data acks while idle and empty must be ignored.
        tick(2);
        m_rd_addr_ack = 1'b1; m_wr_addr_ack = 1'b1; m_rd_ack = 1'b1; m_wr_ack = 1'b1;
        tick(1);
        m_rd_addr_ack = 1'b0; m_wr_addr_ack = 1'b0; m_rd_ack = 1'b0; m_wr_ack = 1'b0;
        check("idle_stray_ack_no_req", 64'({m_rd_req, m_wr_req}), 64'd0);

        // Single port-0 read: address acked 3 cycles late, data 5 cycles after that.
        p0_rd_addr = 22'h000123;
        p0_rd_req  = 1'b1;
        rd_aq.push_back(mk(0, 22'h000123, '0));
        rd_dq.push_back(mk(0, '0, 64'hCAFE));
        addr_handshake(0, 3, 0, '0, port);
        p0_rd_req = 1'b0;
        check("rd_req_released", 64'(m_rd_req), 64'd0);
        tick(4);
        mem_return(0, 64'hCAFE);

        // Both ports hold read requests: grants alternate p0,p1,p0,p1.
        do_reset();
        p0_rd_addr = 22'h000A00; p1_rd_addr = 22'h000A01;
        p0_rd_req  = 1'b1;       p1_rd_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_aq.push_back(mk(i % 2, 22'h000A00 + 22'(i), '0));
            rd_dq.push_back(mk(i % 2, '0, 64'hD0 + 64'(i)));
        end
        for (int i = 0; i < 4; i++) begin
            addr_handshake(0, 1, 0, '0, port);
            if (i < 2) begin
                if (port == 0) p0_rd_addr = 22'h000A02;
                else           p1_rd_addr = 22'h000A03;
            end else begin
                if (port == 0) p0_rd_req = 1'b0;
                else           p1_rd_req = 1'b0;
            end
        end
        tick(2);
        for (int i = 0; i < 4; i++) begin
            mem_return(0, 64'hD0 + 64'(i));
            tick(1);
        end

        // Fill the read tag FIFO to DEPTH, then exercise full, pop and push+pop.
        do_reset();
        p0_rd_addr = 22'h000100;
        p0_rd_req  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_aq.push_back(mk(0, 22'h000100 + 22'(i), '0));
            rd_dq.push_back(mk(0, '0, 64'h1000 + 64'(i)));
            addr_handshake(0, 0, 0, '0, port);
            p0_rd_addr = p0_rd_addr + 22'd1;
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("full_no_grant", 64'(m_rd_req), 64'd0);
        end
        mem_return(0, 64'h1000);
        check("pop_not_used_same_cycle", 64'(m_rd_req), 64'd0);
        p0_rd_addr = 22'h000108;
        rd_aq.push_back(mk(0, 22'h000108, '0));
        rd_dq.push_back(mk(0, '0, 64'h1008));
        addr_handshake(0, 0, 0, '0, port);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("refull_no_grant", 64'(m_rd_req), 64'd0);
        end
        mem_return(0, 64'h1001);
        p0_rd_addr = 22'h000109;
        rd_aq.push_back(mk(0, 22'h000109, '0));
        rd_dq.push_back(mk(0, '0, 64'h1009));
        addr_handshake(0, 0, 1, 64'h1002, port);
        p0_rd_addr = 22'h00010A;
        rd_aq.push_back(mk(0, 22'h00010A, '0));
        rd_dq.push_back(mk(0, '0, 64'h100A));
        addr_handshake(0, 0, 0, '0, port);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("pushpop_full_no_grant", 64'(m_rd_req), 64'd0);
        end
        p0_rd_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_return(0, 64'h1003 + 64'(i));
        end
        check("drain_rd_dq_empty", 64'(rd_dq.size()), 64'd0);

        // Push with a simultaneous data ack at count 0: the ack is ignored.
        p0_rd_addr = 22'h000200;
        p0_rd_req  = 1'b1;
        rd_aq.push_back(mk(0, 22'h000200, '0));
        rd_dq.push_back(mk(0, '0, 64'h2000));
        addr_handshake(0, 0, 1, 64'hDEAD, port);
        p0_rd_req = 1'b0;
        tick(2);
        mem_return(0, 64'h2000);

        // Read and write paths on both ports at once run independently.
        do_reset();
        p0_rd_addr = 22'h000301; p1_rd_addr = 22'h000302;
        p0_wr_addr = 22'h000401; p1_wr_addr = 22'h000402;
        p0_wr_data = 64'hAAAA;   p1_wr_data = 64'hBBBB;
        p0_rd_req = 1'b1; p1_rd_req = 1'b1; p0_wr_req = 1'b1; p1_wr_req = 1'b1;
        rd_aq.push_back(mk(0, 22'h000301, '0));
        rd_aq.push_back(mk(1, 22'h000302, '0));
        wr_aq.push_back(mk(0, 22'h000401, 64'hAAAA));
        wr_aq.push_back(mk(1, 22'h000402, 64'hBBBB));
        rd_dq.push_back(mk(0, '0, 64'h3001));
        rd_dq.push_back(mk(1, '0, 64'h3002));
        wr_dq.push_back(mk(0, '0, '0));
        wr_dq.push_back(mk(1, '0, '0));
        tick(1);
        check("rd_wr_req_together_0", 64'({m_rd_req, m_wr_req}), 64'd3);
        m_rd_addr_ack = 1'b1; m_wr_addr_ack = 1'b1;
        tick(1);
        m_rd_addr_ack = 1'b0; m_wr_addr_ack = 1'b0;
        p0_rd_req = 1'b0; p0_wr_req = 1'b0;
        tick(1);
        check("rd_wr_req_together_1", 64'({m_rd_req, m_wr_req}), 64'd3);
        m_rd_addr_ack = 1'b1; m_wr_addr_ack = 1'b1;
        tick(1);
        m_rd_addr_ack = 1'b0; m_wr_addr_ack = 1'b0;
        p1_rd_req = 1'b0; p1_wr_req = 1'b0;
        tick(1);
        mem_return(1, '0);
        mem_return(0, 64'h3001);
        mem_return(1, '0);
        mem_return(0, 64'h3002);

        // Reset with three reads outstanding and a fourth grant pending.
        do_reset();
        p0_rd_addr = 22'h000500;
        p0_rd_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_aq.push_back(mk(0, 22'h000500 + 22'(i), '0));
            rd_dq.push_back(mk(0, '0, 64'h5000 + 64'(i)));
            addr_handshake(0, 0, 0, '0, port);
            p0_rd_addr = p0_rd_addr + 22'd1;
        end
        tick(1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_return(0, 64'h5000 + 64'(i));
            tick(1);
        end
        p0_rd_addr = 22'h000600;
        p0_rd_req  = 1'b1;
        rd_aq.push_back(mk(0, 22'h000600, '0));
        rd_dq.push_back(mk(0, '0, 64'h6000));
        addr_handshake(0, 1, 0, '0, port);
        p0_rd_req = 1'b0;
        tick(2);
        mem_return(0, 64'h6000);

        tick(2);
        check("queues_drained",
              64'(rd_aq.size() + rd_dq.size() + wr_aq.size() + wr_dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
